// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg
//   Shared types and constants for the UART memory-request engine.
//   - state_e       : FSM states of uart_mem_requester
//   - DEF_FLAG_*    : default opening flag bytes for read / write requests
//   - DEF_ACK_BYTE  : default write acknowledge byte
//   - tx_bytes()    : number of bytes serialised for one request
package uart_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_RECV,
    S_RESP
  } state_e;

  localparam logic [7:0] DEF_FLAG_READ  = 8'h03;
  localparam logic [7:0] DEF_FLAG_WRITE = 8'h04;
  localparam logic [7:0] DEF_ACK_BYTE   = 8'hAA;

  // Flag byte, then the address, then the payload for writes only.
  function automatic int tx_bytes(input logic write, input int addr_bytes, input int data_bytes);
    return 1 + addr_bytes + (write ? data_bytes : 0);
  endfunction

endpackage

// File: rtl/uart_rx_timer.sv
// uart_rx_timer
//   Saturating receive-timeout counter for uart_mem_requester.
//   Ports:
//     clk      in  clock
//     reset    in  synchronous, active-low reset
//     clr      in  restart the timeout window (entry to receive, byte received)
//     en       in  count this cycle (block is waiting for a byte)
//     expired  out the count reaches TIMEOUT_CYCLES on the coming edge
//   TIMEOUT_CYCLES = 0 disables the timer: expired is constant 0.
module uart_rx_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, reset, clr, en};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
      localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      // The clearing cycle itself is elapsed cycle 0, so the register holds 1
      // one cycle later and holds k exactly k cycles after the clear.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = ONE;
        end else if (en && (cnt_q != LIMIT)) begin
          cnt_d = cnt_q + ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Flag expiry in the cycle whose edge brings the count to LIMIT, so the
      // registered response lands exactly TIMEOUT_CYCLES after the last byte.
      // A clear in the same cycle (byte received) always wins.
      assign expired = en && !clr && (cnt_q >= (LIMIT - ONE));
    end
  endgenerate

endmodule

// File: rtl/uart_mem_requester.sv
// uart_mem_requester
//   Serialises a read or write memory request to a UART transmitter
//   (flag byte, address MSB first, write payload MSB first) and collects the
//   response from the UART receiver (DATA_BYTES for reads, one ack for writes),
//   with a receive timeout, abort input and one-cycle response pulse.
//   Ports:
//     clk, reset           clock; synchronous active-low reset
//     abort                return to IDLE without a response
//     req_valid/req_ready  request handshake (req_ready combinational)
//     req_write/addr/wdata request contents, latched on accept
//     rsp_valid/error/data response pulse, error flag, read data
//     tx_start_n/tx_data   byte-send request and byte to the transmitter
//     tx_done              transmitter finished the current byte
//     rx_do/rx_data        receiver byte strobe and byte
module uart_mem_requester
  import uart_mem_pkg::*;
#(
  parameter int         ADDR_BYTES     = 1,
  parameter int         DATA_BYTES     = 2,
  parameter logic [7:0] FLAG_READ      = DEF_FLAG_READ,
  parameter logic [7:0] FLAG_WRITE     = DEF_FLAG_WRITE,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    abort,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_error,
  output logic [8*DATA_BYTES-1:0] rsp_data,
  output logic                    tx_start_n,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  input  logic                    rx_do,
  input  logic [7:0]              rx_data
);

  localparam int N_TX_MAX = tx_bytes(1'b1, ADDR_BYTES, DATA_BYTES);
  localparam int IDX_W    = $clog2(N_TX_MAX);
  localparam int PL_BYTES = ADDR_BYTES + DATA_BYTES;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_RD = IDX_W'(tx_bytes(1'b0, ADDR_BYTES, DATA_BYTES) - 1);
  localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(N_TX_MAX - 1);
  localparam logic [IDX_W-1:0] LAST_RX = IDX_W'(DATA_BYTES - 1);

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      write_q;
  logic [8*ADDR_BYTES-1:0]   addr_q;
  logic [8*DATA_BYTES-1:0]   wdata_q;
  logic                      tx_start_n_q;
  logic [7:0]                tx_data_q;
  logic                      rsp_valid_q;
  logic                      rsp_error_q;
  logic [8*DATA_BYTES-1:0]   rsp_data_q;

  logic                      accept;
  logic [IDX_W-1:0]          idx_inc;
  logic [IDX_W-1:0]          last_idx;
  logic [8*PL_BYTES-1:0]     payload;
  logic [7:0]                tx_byte_d;
  logic [8*DATA_BYTES-1:0]   rsp_data_d;
  logic                      tmr_clr;
  logic                      tmr_en;
  logic                      tmr_expired;

  assign req_ready = reset && (state_q == S_IDLE);
  // abort in IDLE must also block a same-cycle accept
  assign accept    = req_valid && req_ready && !abort;

  assign idx_inc  = idx_q + IDX_ONE;
  assign last_idx = write_q ? LAST_WR : LAST_RD;
  assign payload  = {addr_q, wdata_q};

  // Byte following the one just sent: stream index idx_q+1 maps to payload
  // byte idx_q (the flag byte is stream index 0 and is loaded on accept).
  always_comb begin
    tx_byte_d = 8'h00;
    for (int k = 0; k < PL_BYTES; k++) begin
      if (idx_inc == IDX_W'(k + 1)) begin
        tx_byte_d = payload[8*(PL_BYTES-1-k) +: 8];
      end
    end
  end

  // Received read byte idx_q lands in its MSB-first slot; other slots keep
  // their contents so a timeout leaves the partial data visible.
  always_comb begin
    rsp_data_d = rsp_data_q;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        rsp_data_d[8*(DATA_BYTES-1-k) +: 8] = rx_data;
      end
    end
  end

  // Restart the window on the GAP->RECV transition and on every accepted byte.
  assign tmr_clr = ((state_q == S_GAP) && (idx_q == last_idx)) ||
                   ((state_q == S_RECV) && rx_do);
  assign tmr_en  = (state_q == S_RECV);

  uart_rx_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tx_start_n_q <= 1'b1;
      tx_data_q    <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else if (abort) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tx_start_n_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rsp_valid_q <= 1'b0;
          if (accept) begin
            write_q      <= req_write;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            idx_q        <= '0;
            tx_start_n_q <= 1'b0;
            tx_data_q    <= req_write ? FLAG_WRITE : FLAG_READ;
            rsp_error_q  <= 1'b0;
            state_q      <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_done) begin
            tx_start_n_q <= 1'b1;
            state_q      <= S_GAP;
          end
        end
        S_GAP: begin
          // idx_q still names the byte just sent, so its width only has to
          // cover the last stream index.
          if (idx_q == last_idx) begin
            idx_q   <= '0;
            state_q <= S_RECV;
          end else begin
            idx_q        <= idx_inc;
            tx_data_q    <= tx_byte_d;
            tx_start_n_q <= 1'b0;
            state_q      <= S_SEND;
          end
        end
        S_RECV: begin
          if (rx_do) begin
            if (write_q) begin
              rsp_error_q <= (rx_data != ACK_BYTE);
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              rsp_data_q <= rsp_data_d;
              if (idx_q == LAST_RX) begin
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end else begin
                idx_q <= idx_inc;
              end
            end
          end else if (tmr_expired) begin
            rsp_error_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_start_n = tx_start_n_q;
  assign tx_data    = tx_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_uart_mem_requester.sv
// Testbench for uart_mem_requester: randomized and directed requests against
// an emulated UART, with a response scoreboard and a transmit-stream monitor.
module tb_uart_mem_requester;

  localparam int         AB  = 2;
  localparam int         DB  = 2;
  localparam int         TO  = 20;
  localparam logic [7:0] FR  = 8'h03;
  localparam logic [7:0] FW  = 8'h04;
  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [8*DB-1:0] TOP_MASK = {8'hFF, {(8*(DB-1)){1'b0}}};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              abort = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [8*AB-1:0]   req_addr = '0;
  logic [8*DB-1:0]   req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_error;
  logic [8*DB-1:0]   rsp_data;
  logic              tx_start_n;
  logic [7:0]        tx_data;
  logic              tx_done = 1'b0;
  logic              rx_do = 1'b0;
  logic [7:0]        rx_data = 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct packed {
    logic          err;
    logic [8*DB-1:0] data;
    logic [8*DB-1:0] mask;
  } rsp_t;
  typedef struct packed {
    logic [7:0] b;
    logic       first;
  } txe_t;

  rsp_t sb_q[$];
  int   cyc_q[$];
  txe_t tx_q[$];

  uart_mem_requester #(
    .ADDR_BYTES    (AB),
    .DATA_BYTES    (DB),
    .FLAG_READ     (FR),
    .FLAG_WRITE    (FW),
    .ACK_BYTE      (ACK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_error (rsp_error),
    .rsp_data  (rsp_data),
    .tx_start_n(tx_start_n),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .rx_do     (rx_do),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rsp_valid pops one expected response.
  initial begin
    rsp_t e;
    int   c;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sb_q.size() == 0 || cyc_q.size() == 0) begin
          fail_now("rsp_unexpected", "rsp_valid=1, required no response");
        end else begin
          e = sb_q.pop_front();
          c = cyc_q.pop_front();
          chk("rsp_error", rsp_error, e.err);
          chk("rsp_data", rsp_data & e.mask, e.data & e.mask);
          chk("rsp_cycle", cyc, c);
        end
      end
    end
  end

  // Transmit monitor: each new byte request is compared against the expected
  // stream; within a request the high gap before it must be one cycle.
  initial begin
    logic prev;
    int   hi;
    txe_t e;
    prev = 1'b1;
    hi   = 0;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx_start_n === 1'b0) begin
        if (tx_q.size() == 0) begin
          fail_now("tx_unexpected", "tx_start_n fell, required no byte");
        end else begin
          e = tx_q.pop_front();
          chk("tx_byte", tx_data, e.b);
          if (!e.first) chk("tx_gap", hi, 1);
        end
      end
      hi   = (tx_start_n === 1'b1) ? hi + 1 : 0;
      prev = tx_start_n;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (tx_start_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("tx_wait", "tx_start_n stayed high, required 0 within 30 cycles");
  endtask

  // mode 0: normal; 1: read, one byte then silence; 2: abort during the
  // second address byte; 3: reset pulse in RECV after one byte.
  task automatic run_txn(input bit wr, input logic [8*AB-1:0] a, input logic [8*DB-1:0] d,
                         input int mode, input logic [7:0] ack, input bit stray);
    logic [7:0] txb[$];
    logic [7:0] rxb[$];
    rsp_t       e;
    bit         ok;
    int         n_rx;

    txb.push_back(wr ? FW : FR);
    for (int k = AB - 1; k >= 0; k--) txb.push_back(a[8*k +: 8]);
    if (wr) for (int k = DB - 1; k >= 0; k--) txb.push_back(d[8*k +: 8]);
    if (wr) rxb.push_back(ack);
    else for (int k = DB - 1; k >= 0; k--) rxb.push_back(d[8*k +: 8]);
    n_rx = (mode == 1 || mode == 3) ? 1 : rxb.size();

    e.err  = wr ? (ack != ACK) : (mode == 1);
    e.data = wr ? '0 : d;
    e.mask = wr ? '0 : ((mode == 1) ? TOP_MASK : '1);
    if (mode <= 1) sb_q.push_back(e);
    for (int i = 0; i < txb.size(); i++) tx_q.push_back('{b: txb[i], first: (i == 0)});

    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      fail_now("req_ready_wait", "req_ready stayed low, required 1 within 50 cycles");
      tx_q.delete(); sb_q.delete(); cyc_q.delete();
      return;
    end

    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = (8*AB)'($urandom); req_wdata = (8*DB)'($urandom);
    chk("accept_latency", tx_start_n, 0);

    for (int i = 0; i < txb.size(); i++) begin
      wait_tx(ok);
      if (!ok) begin
        tx_q.delete(); sb_q.delete(); cyc_q.delete();
        return;
      end
      if (mode == 2 && i == 2) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_tx_start_n", tx_start_n, 1);
        chk("abort_req_ready", req_ready, 1);
        tx_q.delete();
        repeat (4) tick();
        return;
      end
      repeat ($urandom_range(0, 3)) begin
        if (stray && $urandom_range(0, 1) == 1) begin
          rx_do = 1'b1; rx_data = 8'($urandom);
        end
        tick();
        rx_do = 1'b0;
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (stray) begin
        rx_do = 1'b1; rx_data = 8'($urandom);
      end
      tick();
      rx_do = 1'b0;
    end

    for (int k = 0; k < n_rx; k++) begin
      repeat ($urandom_range(0, 5)) begin
        if (stray && $urandom_range(0, 1) == 1) tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end
      rx_do = 1'b1; rx_data = rxb[k];
      if (mode == 0 && k == n_rx - 1) cyc_q.push_back(cyc + 1);
      if (mode == 1) cyc_q.push_back(cyc + TO);
      tick();
      rx_do = 1'b0;
    end

    if (mode == 3) begin
      reset = 1'b0;
      tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tx_start_n", tx_start_n, 1);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_rsp_data", rsp_data, 0);
      reset = 1'b1;
      tick();
      chk("rst_release_ready", req_ready, 1);
      return;
    end

    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      fail_now("rsp_wait", "no rsp_valid within 40 cycles, required a response");
      sb_q.delete(); cyc_q.delete();
    end
    tick();
  endtask

  initial begin
    bit              wr;
    logic [7:0]      ack;
    logic [8*AB-1:0] a;
    logic [8*DB-1:0] d;

    repeat (3) tick();
    chk("init_req_ready", req_ready, 0);
    chk("init_tx_start_n", tx_start_n, 1);
    chk("init_tx_data", tx_data, 0);
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_rsp_error", rsp_error, 0);
    chk("init_rsp_data", rsp_data, 0);
    reset = 1'b1;
    tick();
    chk("init_ready_after_reset", req_ready, 1);

    // abort in IDLE blocks a same-cycle accept
    req_valid = 1'b1; abort = 1'b1;
    tick();
    req_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_tx_start_n", tx_start_n, 1);
    chk("idle_abort_req_ready", req_ready, 1);
    tick();

    run_txn(1'b0, 16'h005A, 16'h1234, 0, ACK, 1'b0);
    run_txn(1'b1, 16'hBEEF, 16'hC0DE, 0, 8'hAA, 1'b0);
    run_txn(1'b1, 16'hBEEF, 16'hC0DE, 0, 8'h55, 1'b0);
    run_txn(1'b0, 16'h0123, 16'h77E1, 1, ACK, 1'b0);
    run_txn(1'b0, 16'h005A, 16'h1234, 0, ACK, 1'b1);
    run_txn(1'b1, 16'hBEEF, 16'hC0DE, 0, 8'hAA, 1'b1);
    run_txn(1'b0, 16'hA55A, 16'h9999, 2, ACK, 1'b0);
    run_txn(1'b0, 16'h3C3C, 16'h5AA5, 0, ACK, 1'b0);
    run_txn(1'b0, 16'h4242, 16'hF00D, 3, ACK, 1'b0);
    run_txn(1'b0, 16'h1111, 16'hCAFE, 0, ACK, 1'b0);

    for (int t = 0; t < 24; t++) begin
      wr  = 1'($urandom);
      a   = (8*AB)'($urandom);
      d   = (8*DB)'($urandom);
      ack = ($urandom_range(0, 1) == 1) ? ACK : 8'($urandom);
      run_txn(wr, a, d, 0, ack, 1'($urandom));
    end
    run_txn(1'b0, 16'hFFFF, 16'hABCD, 1, ACK, 1'b1);

    chk("sb_drain", sb_q.size(), 0);
    chk("tx_drain", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
